// File: rtl/pio_initiator_if.sv
// ---------------------------------------------------------------------------
// pio_initiator_if
//   PIO register bus between one bus master (the initiator) and the
//   register block responder.
//
//   Master drives:   reg_bs   block select, held for the whole access
//                    reg_rd   read strobe, one cycle
//                    reg_wr   write strobe, one cycle
//                    reg_addr address, held until the access completes
//                    reg_din  write data, held until the access completes
//   Slave drives:    pio_ack    responder acknowledge (may be stretched to a
//                               full clk_div period)
//                    pio_rvalid address-decode hit, valid while pio_ack=1
//                    pio_rdata  read data, valid while pio_ack=1
// ---------------------------------------------------------------------------
interface pio_initiator_if #(
  parameter int PIO_NBITS = 32
);
  logic                 reg_bs;
  logic                 reg_rd;
  logic                 reg_wr;
  logic [PIO_NBITS-1:0] reg_addr;
  logic [PIO_NBITS-1:0] reg_din;
  logic                 pio_ack;
  logic                 pio_rvalid;
  logic [PIO_NBITS-1:0] pio_rdata;

  modport master (
    output reg_bs,
    output reg_rd,
    output reg_wr,
    output reg_addr,
    output reg_din,
    input  pio_ack,
    input  pio_rvalid,
    input  pio_rdata
  );

  modport slave (
    input  reg_bs,
    input  reg_rd,
    input  reg_wr,
    input  reg_addr,
    input  reg_din,
    output pio_ack,
    output pio_rvalid,
    output pio_rdata
  );
endinterface

// File: rtl/pio_initiator.sv
// ---------------------------------------------------------------------------
// pio_initiator
//   Bus-master end of the PIO register bus. Turns one command at a time into
//   a single register access, waits for the responder's ack (or a timeout),
//   and returns a one-cycle response.
//
// Ports:
//   clk, rst_n        core clock, asynchronous active-low reset
//   req_valid/ready   command handshake (see below)
//   req_wr            1 = write, 0 = read
//   req_addr          register address
//   req_wdata         write data (ignored for reads)
//   rsp_valid         one-cycle response pulse, no backpressure
//   rsp_rdata         read data (0 for writes and errors), held until next rsp
//   rsp_err           0 = ok, 1 = unmapped (ack with rvalid=0), 2 = timeout
//   bus               PIO register bus, master side
//   dbg_state         current FSM state (IDLE=0, STROBE=1, WAIT_ACK=2,
//                     WAIT_IDLE=3)
//
// Handshake: a command transfers on a rising clk edge where req_valid and
//   req_ready are both 1. req_ready is high only in IDLE while pio_ack is
//   low; req_valid in any other cycle is ignored and the command fields need
//   only be stable in the transfer cycle. rsp_valid pulses once per accepted
//   command (never after a reset that interrupted the access).
//
// Parameters:
//   PIO_NBITS       address/data width
//   TIMEOUT_CYCLES  cycles from the strobe to the timeout response (>= 2)
//   TO_NBITS        timeout counter width, 2**TO_NBITS > TIMEOUT_CYCLES
// ---------------------------------------------------------------------------
module pio_initiator #(
  parameter int PIO_NBITS      = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_NBITS       = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // command side
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [PIO_NBITS-1:0] req_addr,
  input  logic [PIO_NBITS-1:0] req_wdata,
  // response side
  output logic                 rsp_valid,
  output logic [PIO_NBITS-1:0] rsp_rdata,
  output logic [1:0]           rsp_err,
  // register bus
  pio_initiator_if.master      bus,
  // debug
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STROBE    = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_IDLE = 2'd3
  } state_t;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_UNMAPPED = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

  // The counter is cleared during the strobe cycle and counts WAIT_ACK
  // cycles. The timeout fires on the edge where it steps to
  // TIMEOUT_CYCLES-1, which puts the timeout response exactly
  // TIMEOUT_CYCLES cycles after the strobe cycle.
  localparam logic [TO_NBITS-1:0] TO_LAST = TO_NBITS'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_NBITS-1:0] TO_FIRE = TO_NBITS'(TIMEOUT_CYCLES - 2);

  state_t               state_q;
  state_t               state_d;
  logic                 wr_q;
  logic [PIO_NBITS-1:0] addr_q;
  logic [PIO_NBITS-1:0] din_q;
  logic [TO_NBITS-1:0]  cnt_q;

  logic                 accept;
  logic                 ack_take;
  logic                 to_take;
  logic                 bs_c;
  logic                 rd_c;
  logic                 wr_c;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and bus controls. Strobes and reg_bs are decoded from the
  // state register alone, so an asynchronous reset drops them at once.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    accept    = 1'b0;
    ack_take  = 1'b0;
    to_take   = 1'b0;
    bs_c      = 1'b0;
    rd_c      = 1'b0;
    wr_c      = 1'b0;

    case (state_q)
      IDLE: begin
        // A still-high ack belongs to an earlier (possibly reset-aborted)
        // access; hold off until it clears.
        req_ready = !bus.pio_ack;
        if (req_valid && !bus.pio_ack) begin
          accept  = 1'b1;
          state_d = STROBE;
        end
      end

      STROBE: begin
        bs_c    = 1'b1;
        rd_c    = !wr_q;
        wr_c    = wr_q;
        state_d = WAIT_ACK;
      end

      WAIT_ACK: begin
        bs_c = 1'b1;
        // Ack has priority over a timeout landing in the same cycle.
        if (bus.pio_ack) begin
          ack_take = 1'b1;
          state_d  = WAIT_IDLE;
        end else if (cnt_q >= TO_FIRE) begin
          to_take = 1'b1;
          state_d = WAIT_IDLE;
        end
      end

      WAIT_IDLE: begin
        // Let a stretched ack run out so it is not mistaken for the ack of
        // the next access.
        if (!bus.pio_ack) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Command latch: address/data stay on the bus until the next command.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
    end else if (accept) begin
      wr_q   <= req_wr;
      addr_q <= req_addr;
      din_q  <= req_wr ? req_wdata : '0;
    end
  end

  // -------------------------------------------------------------------------
  // Timeout counter: cleared in STROBE, counts in WAIT_ACK, saturates.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == STROBE) begin
      cnt_q <= '0;
    end else if (state_q == WAIT_ACK && cnt_q != TO_LAST) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Response: ack data is captured on the same edge that samples pio_ack.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= ERR_OK;
    end else begin
      rsp_valid <= ack_take | to_take;
      if (ack_take) begin
        rsp_rdata <= (!wr_q && bus.pio_rvalid) ? bus.pio_rdata : '0;
        rsp_err   <= bus.pio_rvalid ? ERR_OK : ERR_UNMAPPED;
      end else if (to_take) begin
        rsp_rdata <= '0;
        rsp_err   <= ERR_TIMEOUT;
      end
    end
  end

  assign bus.reg_bs   = bs_c;
  assign bus.reg_rd   = rd_c;
  assign bus.reg_wr   = wr_c;
  assign bus.reg_addr = addr_q;
  assign bus.reg_din  = din_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_pio_initiator.sv
// ---------------------------------------------------------------------------
// tb_pio_initiator
//   Directed bench for pio_initiator with TIMEOUT_CYCLES=16. The responder is
//   played by hand from the stimulus block; inputs change and outputs are
//   checked 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_pio_initiator;
  localparam int W  = 32;
  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         req_valid = 1'b0;
  logic         req_wr    = 1'b0;
  logic [W-1:0] req_addr  = '0;
  logic [W-1:0] req_wdata = '0;
  logic         req_ready;
  logic         rsp_valid;
  logic [W-1:0] rsp_rdata;
  logic [1:0]   rsp_err;
  logic [1:0]   dbg_state;

  pio_initiator_if #(.PIO_NBITS(W)) bus ();

  pio_initiator #(
    .PIO_NBITS      (W),
    .TIMEOUT_CYCLES (TO),
    .TO_NBITS       (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_checks    = 0;
  int n_errors    = 0;
  int wr_pulses   = 0;
  int rd_pulses   = 0;
  int rsp_pulses  = 0;

  // Pulse monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.reg_wr) wr_pulses++;
    if (bus.reg_rd) rd_pulses++;
    if (rsp_valid)  rsp_pulses++;
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ack_set(input logic ack, input logic rvalid, input logic [W-1:0] rdata);
    bus.pio_ack    = ack;
    bus.pio_rvalid = rvalid;
    bus.pio_rdata  = rdata;
  endtask

  task automatic cmd(input logic v, input logic wr, input logic [W-1:0] addr,
                     input logic [W-1:0] wdata);
    req_valid = v;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
  endtask

  int  cyc;
  logic bs_drop;

  // ---------------- directed stimulus ----------------
  initial begin
    ack_set(1'b0, 1'b0, '0);
    tick();
    tick();

    // Reset values
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err",   rsp_err, 0);
    check("rst_reg_bs",    bus.reg_bs, 0);
    check("rst_reg_rd",    bus.reg_rd, 0);
    check("rst_reg_wr",    bus.reg_wr, 0);
    check("rst_reg_addr",  bus.reg_addr, 0);
    check("rst_reg_din",   bus.reg_din, 0);
    check("rst_state",     dbg_state, 0);
    rst_n = 1'b1;
    tick();

    // ---- 1: write 0x1234 to 0x10, ack 2 cycles after the strobe ----
    cmd(1'b1, 1'b1, 32'h10, 32'h0000_1234);
    check("w_req_ready", req_ready, 1);
    tick();
    cmd(1'b0, 1'b0, '0, '0);
    check("w_strobe_wr", bus.reg_wr, 1);
    check("w_strobe_rd", bus.reg_rd, 0);
    check("w_strobe_bs", bus.reg_bs, 1);
    check("w_addr",      bus.reg_addr, 32'h10);
    check("w_din",       bus.reg_din, 32'h1234);
    check("w_busy",      req_ready, 0);
    tick();
    check("w_wait_wr",   bus.reg_wr, 0);
    check("w_wait_bs",   bus.reg_bs, 1);
    tick();
    ack_set(1'b1, 1'b1, 32'hFFFF_FFFF);
    check("w_hold_addr", bus.reg_addr, 32'h10);
    check("w_hold_din",  bus.reg_din, 32'h1234);
    check("w_no_rsp",    rsp_valid, 0);
    tick();
    ack_set(1'b0, 1'b0, '0);
    check("w_rsp_valid", rsp_valid, 1);
    check("w_rsp_err",   rsp_err, 0);
    check("w_rsp_rdata", rsp_rdata, 0);
    check("w_bs_drop",   bus.reg_bs, 0);
    tick();
    check("w_rsp_pulse", rsp_valid, 0);
    check("w_err_hold",  rsp_err, 0);
    check("w_idle",      req_ready, 1);
    check("w_wr_pulses", wr_pulses, 1);

    // ---- 2: read 0x10 -> 0xCAFE_0001 ----
    cmd(1'b1, 1'b0, 32'h10, 32'hFFFF_FFFF);
    tick();
    cmd(1'b0, 1'b0, '0, '0);
    check("r_strobe_rd", bus.reg_rd, 1);
    check("r_strobe_wr", bus.reg_wr, 0);
    check("r_din_zero",  bus.reg_din, 0);
    check("r_addr",      bus.reg_addr, 32'h10);
    tick();
    check("r_rd_once",   bus.reg_rd, 0);
    ack_set(1'b1, 1'b1, 32'hCAFE_0001);
    tick();
    check("r_rsp_valid", rsp_valid, 1);
    check("r_rsp_rdata", rsp_rdata, 32'hCAFE_0001);
    check("r_rsp_err",   rsp_err, 0);
    check("r_rd_pulses", rd_pulses, 1);
    tick();
    check("r_rsp_pulse", rsp_valid, 0);
    check("r_rdata_hold", rsp_rdata, 32'hCAFE_0001);
    check("r_wait_idle", dbg_state, 3);
    check("r_not_ready", req_ready, 0);
    ack_set(1'b0, 1'b0, '0);
    tick();
    check("r_idle",      req_ready, 1);

    // ---- 3: unmapped read of 0x7C ----
    cmd(1'b1, 1'b0, 32'h7C, '0);
    tick();
    cmd(1'b0, 1'b0, '0, '0);
    tick();
    ack_set(1'b1, 1'b0, 32'hDEAD_BEEF);
    tick();
    ack_set(1'b0, 1'b0, '0);
    check("u_rsp_valid", rsp_valid, 1);
    check("u_rsp_err",   rsp_err, 1);
    check("u_rsp_rdata", rsp_rdata, 0);
    tick();
    check("u_idle",      req_ready, 1);

    // ---- 4: timeout, no ack at all ----
    cmd(1'b1, 1'b1, 32'h20, 32'h55);
    tick();                      // now in the strobe cycle
    cmd(1'b0, 1'b0, '0, '0);
    check("t_strobe_wr", bus.reg_wr, 1);
    cyc     = 0;
    bs_drop = 1'b0;
    while (!rsp_valid && cyc < 40) begin
      tick();
      cyc++;
      if (!rsp_valid && !bus.reg_bs) bs_drop = 1'b1;
    end
    check("t_latency",   cyc, TO);
    check("t_bs_held",   bs_drop, 0);
    check("t_rsp_valid", rsp_valid, 1);
    check("t_rsp_err",   rsp_err, 2);
    check("t_rsp_rdata", rsp_rdata, 0);
    check("t_bs_drop",   bus.reg_bs, 0);
    tick();
    check("t_idle",      req_ready, 1);
    check("t_state",     dbg_state, 0);

    // ---- 5: back-to-back reads, ack stretched to 4 cycles ----
    cmd(1'b1, 1'b0, 32'h14, '0);
    tick();
    req_addr = 32'h18;           // second command waits, valid held high
    check("b_a_rd",      bus.reg_rd, 1);
    check("b_a_addr",    bus.reg_addr, 32'h14);
    tick();
    ack_set(1'b1, 1'b1, 32'h1111_AAAA);
    tick();
    check("b_a_rsp",     rsp_valid, 1);
    check("b_a_rdata",   rsp_rdata, 32'h1111_AAAA);
    check("b_a_addr_hold", bus.reg_addr, 32'h14);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("b_a_no_rd", bus.reg_rd, 0);
      check("b_a_no_rsp", rsp_valid, 0);
    end
    ack_set(1'b0, 1'b0, '0);
    tick();
    check("b_idle_ready", req_ready, 1);
    check("b_rd_count",   rd_pulses, 3);
    tick();
    cmd(1'b0, 1'b0, '0, '0);
    check("b_b_rd",      bus.reg_rd, 1);
    check("b_b_addr",    bus.reg_addr, 32'h18);
    tick();
    ack_set(1'b1, 1'b1, 32'h2222_BBBB);
    tick();
    check("b_b_rsp",     rsp_valid, 1);
    check("b_b_rdata",   rsp_rdata, 32'h2222_BBBB);
    check("b_b_err",     rsp_err, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("b_b_no_rsp", rsp_valid, 0);
    end
    ack_set(1'b0, 1'b0, '0);
    tick();
    check("b_idle",      req_ready, 1);

    // ---- 6: reset during WAIT_ACK, then a late ack ----
    cmd(1'b1, 1'b0, 32'h30, '0);
    tick();
    cmd(1'b0, 1'b0, '0, '0);
    tick();
    tick();
    check("x_in_wait",   dbg_state, 2);
    rst_n = 1'b0;
    #1;
    check("x_bs_async",  bus.reg_bs, 0);
    check("x_state_rst", dbg_state, 0);
    tick();
    rst_n = 1'b1;
    ack_set(1'b1, 1'b1, 32'h0000_9999);
    cmd(1'b1, 1'b0, 32'h10, '0);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("x_guard_ready", req_ready, 0);
      check("x_no_rsp",      rsp_valid, 0);
      tick();
      check("x_stay_idle",   dbg_state, 0);
    end
    ack_set(1'b0, 1'b0, '0);
    #1;
    check("x_ready_again", req_ready, 1);
    tick();
    cmd(1'b0, 1'b0, '0, '0);
    check("x_next_rd",   bus.reg_rd, 1);
    check("x_next_addr", bus.reg_addr, 32'h10);
    tick();
    ack_set(1'b1, 1'b1, 32'h0BAD_F00D);
    tick();
    ack_set(1'b0, 1'b0, '0);
    check("x_next_rsp",   rsp_valid, 1);
    check("x_next_rdata", rsp_rdata, 32'h0BAD_F00D);
    check("x_next_err",   rsp_err, 0);
    tick();
    tick();

    // ---- totals ----
    check("tot_rsp_pulses", rsp_pulses, 7);
    check("tot_wr_pulses",  wr_pulses, 2);
    check("tot_rd_pulses",  rd_pulses, 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pio_initiator.md
Name: pio_initiator

Overview:
- Bus-master end of the PIO register bus: converts single-request commands (from the CPU bridge or a config loader) into reg_bs/reg_rd/reg_wr/reg_addr/reg_din accesses.
- Waits for the block's pio_ack, captures pio_rvalid and pio_rdata, then returns a one-cycle response.
- Handles the clk_div-paced ack, a bounded timeout, and ack-deassert spacing between back-to-back accesses.

Parameters:
PIO_NBITS, 32, width of address and data buses
TIMEOUT_CYCLES, 1024, clk cycles to wait for pio_ack before aborting
TO_NBITS, 11, timeout counter width; must satisfy 2^TO_NBITS > TIMEOUT_CYCLES

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  command request
req_ready  out  1  initiator idle, accepts command this cycle
req_wr  in  1  1=write, 0=read
req_addr  in  PIO_NBITS  register address
req_wdata  in  PIO_NBITS  write data
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  PIO_NBITS  read data (0 for writes and errors)
rsp_err  out  2  0=ok, 1=unmapped (ack with rvalid=0), 2=timeout
reg_bs  out  1  block select, held for the whole access
reg_rd  out  1  read strobe, one cycle
reg_wr  out  1  write strobe, one cycle
reg_addr  out  PIO_NBITS  address, held until access completes
reg_din  out  PIO_NBITS  write data, held until access completes
pio_ack  in  1  responder ack, sampled registered
pio_rvalid  in  1  address-decode hit, valid while pio_ack=1
pio_rdata  in  PIO_NBITS  read data, valid while pio_ack=1

Behaviour:
- Reset: state IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; reg_bs/reg_rd/reg_wr=0; reg_addr/reg_din=0; timeout counter=0.
- FSM states: IDLE, STROBE, WAIT_ACK, WAIT_IDLE.
- IDLE: req_ready=1. On req_valid:
  - latch req_addr→reg_addr, req_wdata→reg_din (reg_din=0 for reads) and req_wr.
  - set reg_bs=1 and go to STROBE.
  - If pio_ack is still 1 from a prior access, stay in IDLE with req_ready=0 until pio_ack=0.
- STROBE (exactly one cycle): reg_rd=!req_wr, reg_wr=req_wr; clear the counter; go to WAIT_ACK.
- WAIT_ACK: reg_bs, reg_addr and reg_din stay stable; strobes are 0; the counter increments each cycle.
  - pio_ack=1: capture pio_rvalid and pio_rdata in the same cycle.
    - rsp_rdata = read&&rvalid ? pio_rdata : 0.
    - rsp_err = rvalid ? 0 : 1.
    - rsp_valid=1 next cycle; go to WAIT_IDLE.
  - Counter reaches TIMEOUT_CYCLES-1 with no ack: rsp_valid=1, rsp_err=2, rsp_rdata=0; go to WAIT_IDLE.
  - Ack and timeout in the same cycle: ack wins (ok/unmapped response).
- WAIT_IDLE: reg_bs drops to 0. Remain until pio_ack=0, then go to IDLE.
  - Prevents a stretched ack (held one clk_div period) being taken as the ack of the next access.
  - After a timeout, pio_ack is normally already 0, so WAIT_IDLE lasts 1 cycle.
- Latency: ack sampled at cycle N gives rsp_valid at N+1. Minimum request-to-response is 3 clk plus responder ack delay (up to one clk_div period).
- rsp_valid is a single-cycle pulse with no backpressure; rsp_rdata/rsp_err hold until the next response.
- req_valid is ignored outside IDLE.
- Async reset mid-access: strobes and reg_bs deassert immediately and no response is issued. The responder's ack is then absorbed by the IDLE pio_ack guard.
- The counter saturates and never wraps.

Test Plan:
- Write 0x0000_1234 to decoded address 0x10, with the responder model acking 2 cycles after reg_wr → exactly one reg_wr pulse; reg_addr=0x10 and reg_din=0x1234 held through ack; rsp_valid one cycle later with rsp_err=0.
- Read decoded address 0x10 with pio_rdata=0xCAFE_0001 and rvalid=1 → reg_rd pulse of 1 cycle; rsp_rdata=0xCAFE_0001, rsp_err=0.
- Read unmapped 0x7C, ack with rvalid=0 → rsp_err=1, rsp_rdata=0.
- Responder never acks, TIMEOUT_CYCLES=16 → rsp_valid 16 cycles after the strobe with rsp_err=2; reg_bs drops; next request accepted.
- Back-to-back reads with ack held 4 cycles (clk_div period 4) → second reg_rd issued only after pio_ack=0; two responses with correct per-access data; no early completion.
- Assert rst_n=0 during WAIT_ACK, release, then hold pio_ack=1 for 3 cycles → no rsp_valid; req_ready=0 until pio_ack=0; the following access completes normally.
